pwm_multi_ctrl: RTL and testbench
=================================

Name: pwm_multi_ctrl

Overview:
Multi-channel PWM generator and parametrised successor of the single-channel PWM controller. It supports configurable counter width and channel count, and edge-aligned or center-aligned modes. Output polarity is set per channel, and a global shutdown input and a global resync input act on all channels. Each channel has double-buffered parameters that are applied only at its period boundary. The block sits behind the register/command decoder and drives pad-level PWM outputs.

Parameters:
NUM_CH, 8, number of PWM channels (1..256)
CNT_W, 28, width of period/duty counters and thresholds
CH_W, 8, width of cfg_channel

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_vld  in  1  one-cycle config write strobe
cfg_channel  in  CH_W  target channel index
cfg_en  in  1  channel output enable
cfg_mode  in  1  0 = edge-aligned, 1 = center-aligned
cfg_pol  in  1  0 = active-high, 1 = active-low
cfg_period  in  CNT_W  period threshold P
cfg_hlevel  in  CNT_W  active-level threshold H
kill  in  1  global shutdown strobe
sync_start  in  1  global counter restart strobe
pwm  out  NUM_CH  PWM outputs, registered
cfg_pending  out  NUM_CH  shadow holds parameters not yet applied
period_end  out  NUM_CH  one-cycle pulse per completed period

Behaviour:
- Reset: active state is en=0, P=1, H=0, mode=edge, pol=0. Counter=0, dir=up, shadow cleared. pwm=0, cfg_pending=0, period_end=0.
- Config write: on cfg_vld with cfg_channel < NUM_CH, the shadow registers of that channel load and pending is set. With cfg_channel >= NUM_CH the write is ignored. A second write while pending overwrites the shadow (last write wins).
- A cfg_period of 0 is coerced to 1 on write.
- Edge mode: counter runs 0..P-1 and wraps. Boundary is the cycle with cnt==P-1. Raw = (cnt < H). Period is P cycles, active for min(H,P) cycles starting at cnt=0.
- Center mode: counter runs up 0..P-1, then down P-1..0. Period is 2P cycles. Boundary is dir=down with cnt==0. Raw = (cnt >= P-H). The active pulse lasts 2*min(H,P) cycles, centered on the turnaround.
- H=0 gives a constant inactive output. H>=P gives a constant active output.
- Output: pwm[ch] is registered. In cycle t+1 it equals (en & raw(t)) XOR pol. When en=0 the output sits at the inactive level, which equals pol.
- The counter free-runs even when en=0, so pending updates are still applied at boundaries.
- Boundary handling: if pending, the active parameters load from the shadow and pending clears. The counter restarts at 0 with dir=up.
- period_end[ch] asserts in the cycle after the boundary cycle, for exactly one cycle.
- Write coincident with a boundary: the boundary applies the shadow as it stood before the write, and only if it was already pending. The new write lands in the shadow, and pending=1 after that cycle.
- sync_start: all counters go to 0 with dir=up next cycle. Pending shadows of all channels are applied in the same cycle. period_end does not pulse.
- kill: next cycle, all active en bits are 0 and all pending bits are cleared. A config write in the same cycle is discarded.
- Because en is now 0 (and pwm is registered from en & raw), pwm reaches the inactive level (= pol) one cycle later, i.e. two cycles after kill, not next cycle.
- Counters keep running after kill. Recovery requires a new write with cfg_en=1.
- Priority in a single cycle: rst > kill > sync_start > boundary/config.
- Reset mid-period returns everything to reset values in the next cycle, with no glitch beyond the registered output.
- All comparisons are unsigned CNT_W. P-1 and P-H are computed in CNT_W bits; H>=P is resolved before the subtraction.

Decomposition:
- Package pwm_pkg holds MODE_EDGE=1'b0, MODE_CENTER=1'b1, and the cfg record typedef (en, mode, pol, period, hlevel) parametrised by CNT_W.
- Sub-module pwm_chan holds one channel: shadow, active registers, counter, direction, output flop.
- The top level does channel decode, kill/sync fan-out, and a generate loop over NUM_CH instances.

Test Plan:
- NUM_CH=4, CNT_W=8. Write ch0 en=1 edge P=10 H=3 pol=0 -> after the first boundary, pwm[0] repeats 3 high / 7 low. period_end[0] pulses every 10 cycles. cfg_pending[0] clears at the boundary.
- Write ch1 en=1 center P=8 H=2 -> 16-cycle period, pwm[1] high 4 cycles at cnt 6,7,7,6. Then H=0 -> constant 0. Then H=12 -> constant 1.
- Ch2 pol=1 en=0 -> pwm[2]=1 constantly. Then en=1 P=4 H=1 -> output low 1 cycle, high 3 cycles.
- Mid-period rewrite of ch0 to P=5, written at cnt=4 -> the old 10-cycle period completes, then the 5-cycle period starts. A write at cnt=9 is applied at the following boundary, not the current one.
- Channels 0 and 1 running, pulse kill -> pwm at the inactive level two cycles after kill (en clears next cycle, output flop one cycle later). Pending cleared, outputs stay inactive until rewritten. kill plus cfg_vld in the same cycle -> write discarded.
- Two channels with equal P, offset by a few cycles. Pulse sync_start -> both counters equal 0 next cycle and pwm edges align after that. cfg_channel=7 with NUM_CH=4 -> no state change.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the multi-channel PWM block
//
// Purpose : mode encodings, counter direction enum and the per-channel
//           configuration flag record shared by pwm_chan and pwm_multi_ctrl.
// Ports   : none (package).
package pwm_pkg;

   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Width-independent part of the channel configuration record. The
   // CNT_W-wide period/hlevel fields are appended where CNT_W is known.
   typedef struct packed {
      logic en;
      logic mode;
      logic pol;
   } cfg_flags_t;

endpackage

// File: rtl/pwm_chan.sv
// rtl/pwm_chan.sv - one PWM channel with double-buffered parameters
//
// Purpose : shadow/active parameter registers, period counter with direction,
//           registered PWM output and period-end pulse for a single channel.
// Ports   : clk_i/rst_i        clock, synchronous active-high reset
//           wr_i               config write strobe already decoded for this channel
//           wr_en_i..wr_hlevel_i  configuration written into the shadow
//           kill_i             global shutdown (clears en and pending)
//           sync_i             global counter restart, applies pending shadow
//           pwm_o              registered PWM output
//           pending_o          shadow holds parameters not yet applied
//           period_end_o       one-cycle pulse after each completed period
module pwm_chan #(
   parameter int CNT_W = 28
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_i,
   input  logic             wr_en_i,
   input  logic             wr_mode_i,
   input  logic             wr_pol_i,
   input  logic [CNT_W-1:0] wr_period_i,
   input  logic [CNT_W-1:0] wr_hlevel_i,
   input  logic             kill_i,
   input  logic             sync_i,
   output logic             pwm_o,
   output logic             pending_o,
   output logic             period_end_o
);
   import pwm_pkg::*;

   typedef struct packed {
      cfg_flags_t       f;
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] hlevel;
   } cfg_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam cfg_t ACT_RST = '{
      f:      '{en: 1'b0, mode: MODE_EDGE, pol: 1'b0},
      period: CNT_ONE,
      hlevel: '0
   };

   cfg_t             shadow_q, shadow_d;
   cfg_t             act_q, act_d;
   logic             pending_q, pending_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   dir_e             dir_q, dir_d;
   logic             pwm_q, pwm_d;
   logic             pe_q, pe_d;

   logic [CNT_W-1:0] last_cnt;
   logic             full_on;
   logic             raw;
   logic             boundary;
   cfg_t             wr_cfg;

   // Raw comparator and boundary detection from the active parameters.
   // H>=P is resolved first so P-H never wraps.
   always_comb begin
      last_cnt = act_q.period - CNT_ONE;
      full_on  = (act_q.hlevel >= act_q.period);
      raw      = 1'b0;
      boundary = 1'b0;
      if (act_q.f.mode == MODE_CENTER) begin
         raw      = full_on || (cnt_q >= (act_q.period - act_q.hlevel));
         boundary = (dir_q == DIR_DOWN) && (cnt_q == '0);
      end else begin
         raw      = (cnt_q < act_q.hlevel);
         boundary = (cnt_q == last_cnt);
      end
   end

   always_comb begin
      wr_cfg.f.en   = wr_en_i;
      wr_cfg.f.mode = wr_mode_i;
      wr_cfg.f.pol  = wr_pol_i;
      // A zero period would never reach a boundary; treat it as one.
      wr_cfg.period = (wr_period_i == '0) ? CNT_ONE : wr_period_i;
      wr_cfg.hlevel = wr_hlevel_i;
   end

   always_comb begin
      shadow_d  = shadow_q;
      act_d     = act_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      pwm_d     = (act_q.f.en & raw) ^ act_q.f.pol;
      pe_d      = boundary & ~sync_i;

      // Counter keeps running regardless of en or kill.
      if (sync_i || boundary) begin
         cnt_d = '0;
         dir_d = DIR_UP;
      end else if (dir_q == DIR_DOWN) begin
         cnt_d = cnt_q - CNT_ONE;
      end else if ((act_q.f.mode == MODE_CENTER) && (cnt_q == last_cnt)) begin
         // Turnaround: the top count is held for a second cycle going down.
         dir_d = DIR_DOWN;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end

      if (kill_i) begin
         act_d.f.en = 1'b0;
         pending_d  = 1'b0;
      end else begin
         // The apply uses the shadow as it stood before any same-cycle write.
         if ((sync_i || boundary) && pending_q) begin
            act_d     = shadow_q;
            pending_d = 1'b0;
         end
         if (wr_i) begin
            shadow_d  = wr_cfg;
            pending_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q  <= '0;
         act_q     <= ACT_RST;
         pending_q <= 1'b0;
         cnt_q     <= '0;
         dir_q     <= DIR_UP;
         pwm_q     <= 1'b0;
         pe_q      <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         act_q     <= act_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         pwm_q     <= pwm_d;
         pe_q      <= pe_d;
      end
   end

   assign pwm_o        = pwm_q;
   assign pending_o    = pending_q;
   assign period_end_o = pe_q;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// rtl/pwm_multi_ctrl.sv - multi-channel PWM generator top level
//
// Purpose : decodes config writes to one of NUM_CH channels and fans out the
//           global kill and sync_start strobes to every pwm_chan instance.
// Ports   : clk_i/rst_i          clock, synchronous active-high reset
//           cfg_vld_i            one-cycle config write strobe
//           cfg_channel_i        target channel index
//           cfg_en_i/mode_i/pol_i  enable, 0=edge 1=center, 0=active-high 1=active-low
//           cfg_period_i         period threshold P
//           cfg_hlevel_i         active-level threshold H
//           kill_i               global shutdown strobe
//           sync_start_i         global counter restart strobe
//           pwm_o                registered PWM outputs
//           cfg_pending_o        per-channel shadow-pending flags
//           period_end_o         per-channel period-end pulses
module pwm_multi_ctrl #(
   parameter int NUM_CH = 8,
   parameter int CNT_W  = 28,
   parameter int CH_W   = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cfg_vld_i,
   input  logic [CH_W-1:0]   cfg_channel_i,
   input  logic              cfg_en_i,
   input  logic              cfg_mode_i,
   input  logic              cfg_pol_i,
   input  logic [CNT_W-1:0]  cfg_period_i,
   input  logic [CNT_W-1:0]  cfg_hlevel_i,
   input  logic              kill_i,
   input  logic              sync_start_i,
   output logic [NUM_CH-1:0] pwm_o,
   output logic [NUM_CH-1:0] cfg_pending_o,
   output logic [NUM_CH-1:0] period_end_o
);
   import pwm_pkg::*;

   logic [NUM_CH-1:0] wr_sel;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      // Indices >= NUM_CH match no instance, so such writes are dropped.
      assign wr_sel[g] = cfg_vld_i && (32'(cfg_channel_i) == 32'(g));

      pwm_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .wr_i         (wr_sel[g]),
         .wr_en_i      (cfg_en_i),
         .wr_mode_i    (cfg_mode_i),
         .wr_pol_i     (cfg_pol_i),
         .wr_period_i  (cfg_period_i),
         .wr_hlevel_i  (cfg_hlevel_i),
         .kill_i       (kill_i),
         .sync_i       (sync_start_i),
         .pwm_o        (pwm_o[g]),
         .pending_o    (cfg_pending_o[g]),
         .period_end_o (period_end_o[g])
      );
   end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// tb/tb_pwm_multi_ctrl.sv - scoreboard bench for pwm_multi_ctrl
module tb_pwm_multi_ctrl;
   localparam int NCH = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cfg_vld = 1'b0;
   logic [7:0]     cfg_channel = '0;
   logic           cfg_en = 1'b0;
   logic           cfg_mode = 1'b0;
   logic           cfg_pol = 1'b0;
   logic [7:0]     cfg_period = '0;
   logic [7:0]     cfg_hlevel = '0;
   logic           kill = 1'b0;
   logic           sync_start = 1'b0;
   logic [NCH-1:0] pwm;
   logic [NCH-1:0] cfg_pending;
   logic [NCH-1:0] period_end;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pwm_multi_ctrl #(.NUM_CH(NCH), .CNT_W(8), .CH_W(8)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cfg_vld_i     (cfg_vld),
      .cfg_channel_i (cfg_channel),
      .cfg_en_i      (cfg_en),
      .cfg_mode_i    (cfg_mode),
      .cfg_pol_i     (cfg_pol),
      .cfg_period_i  (cfg_period),
      .cfg_hlevel_i  (cfg_hlevel),
      .kill_i        (kill),
      .sync_start_i  (sync_start),
      .pwm_o         (pwm),
      .cfg_pending_o (cfg_pending),
      .period_end_o  (period_end)
   );

   // Reference model: each channel tracks its position within the period
   // (0 .. P-1 for edge, 0 .. 2P-1 for center) and derives everything from it.
   typedef struct {
      bit en;
      bit mode;
      bit pol;
      int p;
      int h;
   } mcfg_t;

   typedef struct packed {
      logic [NCH-1:0] pwm;
      logic [NCH-1:0] pend;
      logic [NCH-1:0] pe;
   } exp_t;

   mcfg_t act[NCH];
   mcfg_t shd[NCH];
   bit    pend[NCH];
   int    ph[NCH];
   exp_t  exp_q[$];

   function automatic int plen(mcfg_t c);
      return c.mode ? 2 * c.p : c.p;
   endfunction

   function automatic bit is_active(mcfg_t c, int phase);
      int m;
      m = (c.h < c.p) ? c.h : c.p;
      if (!c.mode) return phase < m;
      return (phase >= c.p - m) && (phase < c.p + m);
   endfunction

   task automatic check(string nm, int got, int want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, want, $time);
      end
   endtask

   // Called right at the clock edge with the inputs that edge samples.
   task automatic model_step();
      exp_t e;
      bit   bnd;
      e = '0;
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            act[c].en = 0; act[c].mode = 0; act[c].pol = 0; act[c].p = 1; act[c].h = 0;
            shd[c].en = 0; shd[c].mode = 0; shd[c].pol = 0; shd[c].p = 0; shd[c].h = 0;
            pend[c] = 0;
            ph[c]   = 0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            e.pwm[c] = (act[c].en && is_active(act[c], ph[c])) ^ act[c].pol;
            bnd      = (ph[c] == plen(act[c]) - 1);
            e.pe[c]  = bnd && !sync_start;
            if (kill) begin
               act[c].en = 0;
               pend[c]   = 0;
            end else begin
               if ((sync_start || bnd) && pend[c]) begin
                  act[c]  = shd[c];
                  pend[c] = 0;
               end
               if (cfg_vld && int'(cfg_channel) == c) begin
                  shd[c].en   = cfg_en;
                  shd[c].mode = cfg_mode;
                  shd[c].pol  = cfg_pol;
                  shd[c].p    = (cfg_period == 0) ? 1 : int'(cfg_period);
                  shd[c].h    = int'(cfg_hlevel);
                  pend[c]     = 1;
               end
            end
            ph[c]     = (sync_start || bnd) ? 0 : ph[c] + 1;
            e.pend[c] = pend[c];
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic run(int n);
      repeat (n) cycle();
   endtask

   task automatic wr(int ch, bit en, bit mode, bit pol, int p, int h);
      cfg_channel = 8'(ch);
      cfg_en      = en;
      cfg_mode    = mode;
      cfg_pol     = pol;
      cfg_period  = 8'(p);
      cfg_hlevel  = 8'(h);
      cfg_vld     = 1'b1;
      cycle();
      cfg_vld     = 1'b0;
   endtask

   task automatic count_win(int ch, int n, output int hi, output int pe);
      hi = 0;
      pe = 0;
      repeat (n) begin
         cycle();
         hi += int'(pwm[ch]);
         pe += int'(period_end[ch]);
      end
   endtask

   // Monitor: every output cycle is checked against the next scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_pwm", int'(pwm), int'(e.pwm));
            check("sb_pending", int'(cfg_pending), int'(e.pend));
            check("sb_period_end", int'(period_end), int'(e.pe));
         end
      end
   end

   initial begin
      int hi;
      int pe;
      run(3);
      rst = 1'b0;
      check("reset_pwm", int'(pwm), 0);
      check("reset_pending", int'(cfg_pending), 0);

      // ch0 edge P=10 H=3
      wr(0, 1, 0, 0, 10, 3);
      run(20);
      count_win(0, 10, hi, pe);
      check("ch0_edge_high", hi, 3);
      check("ch0_edge_pe", pe, 1);
      check("ch0_pending_clr", int'(cfg_pending[0]), 0);

      // ch1 center P=8 H=2, then H=0, then H=12
      wr(1, 1, 1, 0, 8, 2);
      run(20);
      count_win(1, 16, hi, pe);
      check("ch1_center_high", hi, 4);
      check("ch1_center_pe", pe, 1);
      wr(1, 1, 1, 0, 8, 0);
      run(20);
      count_win(1, 16, hi, pe);
      check("ch1_h0_high", hi, 0);
      wr(1, 1, 1, 0, 8, 12);
      run(20);
      count_win(1, 16, hi, pe);
      check("ch1_hbig_high", hi, 16);

      // ch2 active-low
      wr(2, 0, 0, 1, 4, 1);
      run(5);
      count_win(2, 8, hi, pe);
      check("ch2_dis_high", hi, 8);
      wr(2, 1, 0, 1, 4, 1);
      run(8);
      count_win(2, 4, hi, pe);
      check("ch2_low_high", hi, 3);

      // ch0 rewrites mid-period
      run(4);
      wr(0, 1, 0, 0, 5, 2);
      run(15);
      count_win(0, 5, hi, pe);
      check("ch0_p5_high", hi, 2);
      check("ch0_p5_pe", pe, 1);
      run(3);
      wr(0, 1, 0, 0, 7, 4);
      run(2);
      wr(0, 1, 0, 0, 5, 2);
      run(12);

      // kill with ch0 and ch1 running
      kill = 1'b1;
      cycle();
      kill = 1'b0;
      cycle();
      check("kill_pwm_inactive", int'(pwm[1:0]), 0);
      check("kill_pending_clr", int'(cfg_pending), 0);
      count_win(1, 16, hi, pe);
      check("kill_stays_off", hi, 0);
      kill = 1'b1;
      wr(0, 1, 0, 0, 5, 2);
      kill = 1'b0;
      check("kill_wr_discard", int'(cfg_pending[0]), 0);
      run(8);
      count_win(0, 10, hi, pe);
      check("kill_wr_no_output", hi, 0);

      // sync_start alignment of ch0 and ch3
      wr(0, 1, 0, 0, 6, 2);
      run(3);
      wr(3, 1, 0, 0, 6, 2);
      run(20);
      sync_start = 1'b1;
      cycle();
      sync_start = 1'b0;
      check("sync_no_pe", int'({period_end[3], period_end[0]}), 0);
      for (int i = 1; i <= 6; i++) begin
         cycle();
         check("sync_ch0", int'(pwm[0]), (i <= 2) ? 1 : 0);
         check("sync_ch3", int'(pwm[3]), (i <= 2) ? 1 : 0);
      end
      wr(7, 1, 1, 1, 3, 1);
      check("bad_channel_ignored", int'(cfg_pending), 0);
      run(10);

      // randomized traffic, checked by the scoreboard
      for (int n = 0; n < 2500; n++) begin
         cfg_vld     = ($urandom_range(0, 5) == 0);
         cfg_channel = 8'($urandom_range(0, 7));
         cfg_en      = ($urandom_range(0, 3) != 0);
         cfg_mode    = 1'($urandom_range(0, 1));
         cfg_pol     = 1'($urandom_range(0, 1));
         cfg_period  = 8'($urandom_range(0, 12));
         cfg_hlevel  = 8'($urandom_range(0, 14));
         kill        = ($urandom_range(0, 199) == 0);
         sync_start  = ($urandom_range(0, 99) == 0);
         rst         = ($urandom_range(0, 499) == 0);
         cycle();
      end
      cfg_vld    = 1'b0;
      kill       = 1'b0;
      sync_start = 1'b0;
      rst        = 1'b0;
      run(2);
      @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
